// File: rtl/trdb_pkg.sv
// Shared trace-encoder definitions: itype encoding, opcode masks and the
// static control-flow decoder used by the instruction-type classifier.
package trdb_pkg;

  localparam int ITYPE_LEN = 3;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_STD      = 3'd0,
    ITYPE_BR_NT    = 3'd1,
    ITYPE_BR_T     = 3'd2,
    ITYPE_UPDISCON = 3'd3,
    ITYPE_PRIV_RET = 3'd4,
    ITYPE_IMPL_RET = 3'd5
  } itype_e;

  localparam logic [4:0] X_RA = 5'd1;
  localparam logic [4:0] X_T0 = 5'd5;

  localparam logic [6:0]  OPC_BRANCH = 7'h63;
  localparam logic [31:0] MASK_JAL   = 32'h0000_007f;
  localparam logic [31:0] MATCH_JAL  = 32'h0000_006f;
  localparam logic [31:0] MASK_JALR  = 32'h0000_707f;
  localparam logic [31:0] MATCH_JALR = 32'h0000_0067;

  localparam logic [15:0] MASK_C_JAL     = 16'he003;
  localparam logic [15:0] MATCH_C_JAL    = 16'h2001;
  localparam logic [15:0] MASK_C_JALR    = 16'hf07f;
  localparam logic [15:0] MATCH_C_JALR   = 16'h9002;
  localparam logic [15:0] MASK_C_JR      = 16'hf07f;
  localparam logic [15:0] MATCH_C_JR     = 16'h8002;
  localparam logic [15:0] MASK_C_BRANCH  = 16'hc003;
  localparam logic [15:0] MATCH_C_BRANCH = 16'hc001;

  localparam logic [31:0] INSN_MRET = 32'h3020_0073;
  localparam logic [31:0] INSN_SRET = 32'h1020_0073;
  localparam logic [31:0] INSN_URET = 32'h0020_0073;

  typedef struct packed {
    logic branch;
    logic call;       // any linking jump (pushes the return address)
    logic call_jalr;  // linking jump whose target is register-indirect
    logic ret;
    logic jump;
    logic priv_ret;
  } decode_t;

  function automatic decode_t decode_inst(input logic [31:0] inst, input logic c);
    decode_t    d;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rd_link;
    logic       is_jal;
    logic       is_jalr;
    logic       is_c_jr;
    logic       is_c_jalr;
    d         = '0;
    rd        = inst[11:7];
    rs1       = inst[19:15];
    rd_link   = (rd == X_RA) || (rd == X_T0);
    is_jal    = (inst & MASK_JAL) == MATCH_JAL;
    is_jalr   = (inst & MASK_JALR) == MATCH_JALR;
    // The compressed register-jump forms carry rs1 in the rd slot.
    is_c_jr   = ((inst[15:0] & MASK_C_JR) == MATCH_C_JR) && (rd != 5'd0);
    is_c_jalr = ((inst[15:0] & MASK_C_JALR) == MATCH_C_JALR) && (rd != 5'd0);
    if (c) begin
      d.branch    = (inst[15:0] & MASK_C_BRANCH) == MATCH_C_BRANCH;
      d.call      = ((inst[15:0] & MASK_C_JAL) == MATCH_C_JAL) || is_c_jalr;
      d.call_jalr = is_c_jalr;
      d.ret       = is_c_jr && (rd == X_RA);
      d.jump      = is_c_jr && (rd != X_RA);
    end else begin
      d.branch    = inst[6:0] == OPC_BRANCH;
      d.call      = (is_jal || is_jalr) && rd_link;
      d.call_jalr = is_jalr && rd_link;
      d.ret       = is_jalr && (rd == 5'd0) && (rs1 == X_RA) && (inst[31:20] == 12'd0);
      d.jump      = is_jalr && !rd_link && !d.ret;
      d.priv_ret  = (inst == INSN_MRET) || (inst == INSN_SRET) || (inst == INSN_URET);
    end
    return d;
  endfunction

endpackage

// File: rtl/trdb_ras.sv
// Circular return-address stack: when full, a push overwrites the oldest
// entry and the count saturates. A push and pop together replace the top.
module trdb_ras #(
  parameter int RAS_DEPTH = 8,
  parameter int PC_LEN    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic [PC_LEN-1:0]            i_data,
  output logic [PC_LEN-1:0]            o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_cnt,
  output logic                         o_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_LEN-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  w_top_ptr;
  logic              w_pop_ok;

  assign w_top_ptr = r_wr_ptr - PTR_W'(1);
  assign w_pop_ok  = i_pop && (r_cnt != '0);
  assign o_top     = r_mem[w_top_ptr];
  assign o_cnt     = r_cnt;
  assign o_full    = r_cnt == CNT_W'(RAS_DEPTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_push && !w_pop_ok) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (!o_full) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_pop_ok && !i_push) begin
      r_wr_ptr <= w_top_ptr;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // NOTE: entries carry no reset; the count alone decides what is valid,
  // so stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (i_push && !i_clear) begin
      if (w_pop_ok) r_mem[w_top_ptr] <= i_data;
      else          r_mem[r_wr_ptr]  <= i_data;
    end
  end

endmodule

// File: rtl/trdb_itype_detector_ras.sv
// Trace itype classifier: holds each retired instruction until its successor
// retires, resolves branch direction and compresses implicit returns via a RAS.
module trdb_itype_detector_ras
  import trdb_pkg::*;
#(
  parameter int PC_LEN    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  input  logic [31:0]                 inst_data_i,
  input  logic                        compressed_i,
  input  logic [PC_LEN-1:0]           iaddr_i,
  input  logic                        implicit_ret_en_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  output logic [PC_LEN-1:0]           iaddr_o,
  output logic [ITYPE_LEN-1:0]        itype_o,
  output logic                        ras_ovf_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_cnt_o
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              r_hold_valid;
  logic [PC_LEN-1:0] r_hold_addr;
  logic [31:0]       r_hold_inst;
  logic              r_hold_c;

  logic              r_valid;
  logic [PC_LEN-1:0] r_iaddr;
  itype_e            r_itype;
  logic              r_ovf;

  decode_t           w_dec;
  logic [PC_LEN-1:0] w_nxt;
  logic              w_emit;
  logic              w_pop_ok;
  logic              w_push;
  logic              w_pop;
  itype_e            w_itype;
  logic [PC_LEN-1:0] w_ras_top;
  logic [CNT_W-1:0]  w_ras_cnt;
  logic              w_ras_full;

  assign w_dec    = decode_inst(r_hold_inst, r_hold_c);
  assign w_nxt    = r_hold_addr + (r_hold_c ? PC_LEN'(2) : PC_LEN'(4));
  assign w_emit   = r_hold_valid && (valid_i || flush_i);
  assign w_pop_ok = valid_i && implicit_ret_en_i && (w_ras_cnt != '0);
  // A flush discards the held instruction's stack effect; the RAS is cleared.
  assign w_push   = w_emit && valid_i && !flush_i && w_dec.call;

  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_itype = ITYPE_STD;
    w_pop   = 1'b0;
    if (w_dec.priv_ret) begin
      w_itype = ITYPE_PRIV_RET;
    end else if (w_dec.branch) begin
      w_itype = (valid_i && (iaddr_i != w_nxt)) ? ITYPE_BR_T : ITYPE_BR_NT;
    end else if (w_dec.ret) begin
      w_itype = ITYPE_UPDISCON;
      if (w_pop_ok) begin
        if (w_ras_top == iaddr_i) w_itype = ITYPE_IMPL_RET;
        w_pop = w_emit && !flush_i;
      end
    end else if (w_dec.jump || w_dec.call_jalr) begin
      w_itype = ITYPE_UPDISCON;
    end
  end

  trdb_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_LEN    (PC_LEN)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_data  (w_nxt),
    .o_top   (w_ras_top),
    .o_cnt   (w_ras_cnt),
    .o_full  (w_ras_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_inst  <= '0;
      r_hold_c     <= 1'b0;
    end else if (valid_i) begin
      r_hold_valid <= 1'b1;
      r_hold_addr  <= iaddr_i;
      r_hold_inst  <= inst_data_i;
      r_hold_c     <= compressed_i;
    end else if (flush_i) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_iaddr <= '0;
      r_itype <= ITYPE_STD;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_ovf   <= w_push && !w_pop && w_ras_full;
      if (w_emit) begin
        r_iaddr <= r_hold_addr;
        r_itype <= w_itype;
      end
    end
  end

  assign valid_o   = r_valid;
  assign iaddr_o   = r_iaddr;
  assign itype_o   = r_itype;
  assign ras_ovf_o = r_ovf;
  assign ras_cnt_o = w_ras_cnt;

endmodule
